// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: APB read bus between the fetch sequencer (master) and instruction memory (slave)
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    modport master (output psel, penable, paddr, input prdata, pready, pslverr);
    modport slave (input psel, penable, paddr, output prdata, pready, pslverr);
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: APB word fetch split into 16-bit instructions through a 4-entry FIFO with stall and redirect
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [15:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_err
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HALT} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] fetch_pc, word_pc, target_pc;
    logic [15:0]       hw_q [4];
    logic [ADDR_W-1:0] pc_q [4];
    logic [1:0]        rd_ptr, wr_ptr, push_n;
    logic [2:0]        count;
    logic              discard, done, keep, err, pop;

    assign word_pc    = fetch_pc & ~ADDR_W'(3);
    assign target_pc  = redirect_pc & ~ADDR_W'(1);
    assign done       = state == ACCESS && bus.pready;
    assign keep       = done && !discard && !redirect;
    assign err        = keep && bus.pslverr;
    assign push_n     = keep && !bus.pslverr ? (fetch_pc[1] ? 2'd1 : 2'd2) : 2'd0;
    assign pop        = inst_valid && !stall;
    assign bus.psel   = state == SETUP || state == ACCESS;
    assign bus.penable = state == ACCESS;
    assign inst_valid = count != 3'd0;
    assign inst       = hw_q[rd_ptr];
    assign inst_pc    = pc_q[rd_ptr];

    // A fetch is only started with room for two halfwords, so pushes never overflow.
    always_comb begin
        state_n = state == SETUP  ? ACCESS :
                  state == ACCESS ? (!bus.pready ? ACCESS : err ? HALT : IDLE) :
                  (redirect || (state == IDLE && count <= 3'd2)) ? SETUP : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus.paddr <= RESET_PC & ~ADDR_W'(3);
            fetch_pc  <= RESET_PC;
            discard   <= 1'b0;
            fetch_err <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            for (int i = 0; i < 4; i++) begin
                hw_q[i] <= '0;
                pc_q[i] <= RESET_PC;
            end
        end else begin
            state <= state_n;
            if (state_n == SETUP)
                bus.paddr <= (redirect ? target_pc : fetch_pc) & ~ADDR_W'(3);
            fetch_pc  <= redirect ? target_pc : push_n != 2'd0 ? word_pc + ADDR_W'(4) : fetch_pc;
            // An in-flight transfer cannot be aborted, so its data is marked for dropping.
            discard   <= redirect && (state == SETUP || (state == ACCESS && !bus.pready)) ? 1'b1 :
                         done ? 1'b0 : discard;
            fetch_err <= redirect ? 1'b0 : err ? 1'b1 : fetch_err;
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count  <= count + {1'b0, push_n} - {2'b0, pop};
                rd_ptr <= rd_ptr + {1'b0, pop};
                wr_ptr <= wr_ptr + push_n;
            end
            if (push_n != 2'd0) begin
                hw_q[wr_ptr] <= fetch_pc[1] ? bus.prdata[31:16] : bus.prdata[15:0];
                pc_q[wr_ptr] <= fetch_pc;
            end
            if (push_n == 2'd2) begin
                hw_q[wr_ptr + 2'd1] <= bus.prdata[31:16];
                pc_q[wr_ptr + 2'd1] <= fetch_pc + ADDR_W'(2);
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table vectors, directed corner sequences and a randomized queue-model check
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid, fetch_err;
    logic [15:0] inst;
    logic [31:0] inst_pc;
    logic        rdy = 1'b1, serr = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(32)) bus ();

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .fetch_err(fetch_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h0 ? 32'hBBBB_AAAA : {a[15:0] + 16'h1002, a[15:0] + 16'h1000};
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    assign bus.prdata  = mem_word(bus.paddr);
    assign bus.pready  = rdy;
    assign bus.pslverr = serr || (bus.paddr == err_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rdy = 1'b1; serr = 1'b0; err_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_setup(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            if (bus.psel && !bus.penable) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            if (inst_valid) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        psel, penable;
        logic [31:0] paddr;
        logic        iv;
        logic [15:0] inst;
        logic [31:0] pc;
    } vec_t;

    typedef struct {
        logic [15:0] hw;
        logic [31:0] pc;
    } ent_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [7];
        ent_t        q [$];
        logic [31:0] mfpc, w, pa;
        bit          merr, dirty, ok, seen, setup, access;
        tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0000, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'h0000, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 16'h0000, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 16'hAAAA, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h4, 1'b1, 16'hBBBB, 32'h2};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h4, 1'b0, 16'h0000, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h4, 1'b1, 16'h1004, 32'h4};

        // Zero-wait fetch from reset
        do_reset();
        for (int i = 0; i < 7; i++) begin
            stall = tbl[i].stall;
            chk($sformatf("t1_psel[%0d]", i), bus.psel, tbl[i].psel);
            chk($sformatf("t1_penable[%0d]", i), bus.penable, tbl[i].penable);
            chk($sformatf("t1_paddr[%0d]", i), bus.paddr, tbl[i].paddr);
            chk($sformatf("t1_valid[%0d]", i), inst_valid, tbl[i].iv);
            if (tbl[i].iv || i == 0) begin
                chk($sformatf("t1_inst[%0d]", i), inst, tbl[i].inst);
                chk($sformatf("t1_pc[%0d]", i), inst_pc, tbl[i].pc);
            end
            if (i == 0) chk("t1_reset_err", fetch_err, 0);
            @(negedge clk);
        end

        // Stall fills the FIFO, then drains in order and refetches at 8
        do_reset();
        stall = 1'b1;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t2_psel_full", bus.psel, 0);
            @(negedge clk);
        end
        chk("t2_valid_full", inst_valid, 1);
        stall = 1'b0;
        seen = 1'b0;
        pa = '0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_valid[%0d]", k), inst_valid, 1);
            chk($sformatf("t2_pc[%0d]", k), inst_pc, 32'(2 * k));
            chk($sformatf("t2_inst[%0d]", k), inst, hw_at(32'(2 * k)));
            if (!seen && bus.psel && !bus.penable) begin seen = 1'b1; pa = bus.paddr; end
            @(negedge clk);
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.psel && !bus.penable) begin seen = 1'b1; pa = bus.paddr; end
            else @(negedge clk);
        end
        chk("t2_refetch_seen", seen, 1);
        chk("t2_refetch_paddr", pa, 32'h8);

        // Redirect during a waited ACCESS drops the old data
        do_reset();
        rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t3_in_access", bus.penable, 1);
        redirect = 1'b1; redirect_pc = 32'h0106;
        @(negedge clk);
        redirect = 1'b0;
        chk("t3_flush_valid0", inst_valid, 0);
        @(negedge clk);
        chk("t3_flush_valid1", inst_valid, 0);
        @(negedge clk);
        rdy = 1'b1;
        chk("t3_flush_valid2", inst_valid, 0);
        @(negedge clk);
        chk("t3_dropped_valid", inst_valid, 0);
        wait_setup(10, ok);
        chk("t3_setup_seen", ok, 1);
        chk("t3_paddr", bus.paddr, 32'h104);
        wait_valid(10, ok);
        chk("t3_inst_seen", ok, 1);
        chk("t3_pc", inst_pc, 32'h106);
        chk("t3_inst", inst, hw_at(32'h106));
        @(negedge clk);
        chk("t3_single", inst_valid, 0);

        // Redirect coincident with a pop and a completing push
        do_reset();
        stall = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_pre_access", bus.penable, 1);
        chk("t4_pre_valid", inst_valid, 1);
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        chk("t4_no_stale", inst_valid, 0);
        wait_valid(12, ok);
        chk("t4_inst_seen", ok, 1);
        chk("t4_pc", inst_pc, 32'h40);
        chk("t4_inst", inst, hw_at(32'h40));

        // Slave error halts fetch until redirect
        do_reset();
        err_addr = 32'h10;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (fetch_err) ok = 1'b1;
            else @(negedge clk);
        end
        chk("t5_err_set", ok, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_halt_psel", bus.psel, 0);
            @(negedge clk);
        end
        err_addr = 32'hFFFF_FFFF;
        redirect = 1'b1; redirect_pc = 32'h20;
        @(negedge clk);
        redirect = 1'b0;
        chk("t5_err_clear", fetch_err, 0);
        chk("t5_setup", bus.psel && !bus.penable, 1);
        chk("t5_paddr", bus.paddr, 32'h20);

        // Asynchronous reset mid-ACCESS
        do_reset();
        rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_access", bus.penable, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_psel", bus.psel, 0);
        chk("t6_penable", bus.penable, 0);
        chk("t6_paddr", bus.paddr, 32'h0);
        chk("t6_valid", inst_valid, 0);
        chk("t6_err", fetch_err, 0);

        // Randomized run against a halfword-stream queue model
        do_reset();
        q.delete();
        mfpc = 32'h0; merr = 1'b0; dirty = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            chk("r_valid", inst_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("r_inst", inst, q[0].hw);
                chk("r_pc", inst_pc, q[0].pc);
            end
            chk("r_err", fetch_err, merr);
            if (merr) chk("r_halt_psel", bus.psel, 0);
            setup  = bus.psel && !bus.penable;
            access = bus.psel && bus.penable;
            if (setup) begin
                chk("r_paddr", bus.paddr, {mfpc[31:2], 2'b00});
                dirty = 1'b0;
            end
            stall       = ($urandom % 4) == 0;
            redirect    = ($urandom % 14) == 0;
            redirect_pc = ($urandom % 8) == 0 ? 32'hFFFF_FFF8 + ($urandom % 8) : $urandom_range(0, 511);
            rdy         = ($urandom % 3) != 0;
            serr        = ($urandom % 25) == 0;
            if (redirect) begin
                q.delete();
                mfpc = redirect_pc & ~32'h1;
                merr = 1'b0;
                if (setup || (access && !rdy)) dirty = 1'b1;
            end else begin
                if (q.size() != 0 && !stall) void'(q.pop_front());
                if (access && rdy && !dirty) begin
                    if (serr) merr = 1'b1;
                    else begin
                        w = mem_word({mfpc[31:2], 2'b00});
                        if (!mfpc[1]) q.push_back('{w[15:0], {mfpc[31:2], 2'b00}});
                        q.push_back('{w[31:16], {mfpc[31:2], 2'b10}});
                        mfpc = {mfpc[31:2], 2'b00} + 32'd4;
                    end
                end
            end
            chk("r_depth", q.size() <= 4, 1);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
